// File: rtl/maxpool_flatten.sv
// 2x2 stride-2 max pooling over two layer-0 channels, writing each pooled
// pixel to its layer-1 channel map and, interleaved by channel, to layer 2.
module maxpool_flatten #(
  parameter int IMG_W = 64,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [11:0]   caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [11:0]   caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int PW = IMG_W / 2;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(PW - 1);

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0C0 = 3'b001;
  localparam logic [2:0] SEL_L0C1 = 3'b010;
  localparam logic [2:0] SEL_L1C0 = 3'b011;
  localparam logic [2:0] SEL_L1C1 = 3'b100;
  localparam logic [2:0] SEL_L2   = 3'b101;

  typedef enum logic [2:0] {
    IDLE, READ, CMP, WR_L1, WR_L2, NEXT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [CW-1:0] r_q, r_d, c_q, c_d;
  logic          ch_q, ch_d;
  logic [DW-1:0] max_q, max_d;

  logic          busy_q, busy_d, done_q, done_d;
  logic          crd_q, crd_d, cwr_q, cwr_d;
  logic [11:0]   caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
  logic [DW-1:0] cdata_wr_q, cdata_wr_d;
  logic [2:0]    csel_q, csel_d;

  logic [11:0]   rowBase, readBase, kOff, pixIdx;
  logic          lastGroup;

  assign lastGroup = (r_q == LAST_POS) && (c_q == LAST_POS) && ch_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    ch_d    = ch_q;
    max_d   = max_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          k_d     = 2'd0;
          r_d     = '0;
          c_d     = '0;
          ch_d    = 1'b0;
        end
      end
      READ: begin
        if (k_q == 2'd3) state_d = CMP;
        else             k_d     = k_q + 2'd1;
      end
      CMP:   state_d = WR_L1;
      WR_L1: state_d = WR_L2;
      WR_L2: begin
        k_d = 2'd0;
        if (lastGroup) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          ch_d    = ~ch_q;
          if (ch_q) begin
            if (c_q == LAST_POS) begin
              c_d = '0;
              r_d = r_q + 1'b1;
            end else begin
              c_d = c_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data lags the strobe by one cycle: the first sample seeds the max.
    if (state_q == READ && k_q == 2'd1) begin
      max_d = cdata_rd;
    end else if ((state_q == READ && k_q >= 2'd2) || state_q == CMP) begin
      if ($signed(cdata_rd) > $signed(max_q)) max_d = cdata_rd;
    end
  end

  // Outputs are registered from the next-state view so they line up with k.
  always_comb begin
    rowBase  = 12'(r_d) * 12'(2 * IMG_W);
    readBase = rowBase + (12'(c_d) << 1);
    pixIdx   = 12'(r_d) * 12'(PW) + 12'(c_d);
    unique case (k_d)
      2'd0: kOff = 12'd0;
      2'd1: kOff = 12'd1;
      2'd2: kOff = 12'(IMG_W);
      2'd3: kOff = 12'(IMG_W + 1);
    endcase

    busy_d     = (state_d == READ) || (state_d == CMP) ||
                 (state_d == WR_L1) || (state_d == WR_L2);
    done_d     = (state_d == DONE);
    crd_d      = (state_d == READ);
    cwr_d      = (state_d == WR_L1) || (state_d == WR_L2);
    caddr_rd_d = caddr_rd_q;
    caddr_wr_d = caddr_wr_q;
    cdata_wr_d = cdata_wr_q;
    csel_d     = SEL_NONE;

    if (state_d == READ) begin
      caddr_rd_d = readBase + kOff;
      csel_d     = ch_d ? SEL_L0C1 : SEL_L0C0;
    end else if (state_d == WR_L1) begin
      caddr_wr_d = pixIdx;
      cdata_wr_d = max_d;
      csel_d     = ch_d ? SEL_L1C1 : SEL_L1C0;
    end else if (state_d == WR_L2) begin
      caddr_wr_d = (pixIdx << 1) + 12'(ch_d);
      cdata_wr_d = max_d;
      csel_d     = SEL_L2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      r_q        <= '0;
      c_q        <= '0;
      ch_q       <= 1'b0;
      max_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      caddr_rd_q <= 12'd0;
      caddr_wr_q <= 12'd0;
      cdata_wr_q <= '0;
      csel_q     <= SEL_NONE;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      r_q        <= r_d;
      c_q        <= c_d;
      ch_q       <= ch_d;
      max_q      <= max_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      csel_q     <= csel_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign crd      = crd_q;
  assign cwr      = cwr_q;
  assign caddr_rd = caddr_rd_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign csel     = csel_q;

endmodule

// File: tb/tb_maxpool_flatten.sv
// Scoreboard bench for maxpool_flatten: a ramp image with two planted signed
// windows, a start poke mid-run, and a reset abort followed by a clean rerun.
module tb_maxpool_flatten;

  localparam int DW = 20;

  typedef struct packed {
    logic [2:0]    sel;
    logic [11:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [2:0]  sel;
    logic [11:0] addr;
  } rd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, crd, cwr;
  logic [11:0]   caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd = '0;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] l0c0 [4096];
  logic [DW-1:0] l0c1 [4096];

  wr_t wrQ[$];
  rd_t rdQ[$];

  int checks = 0;
  int errors = 0;
  int busyCycles = 0, crdCh0 = 0, crdCh1 = 0, l2Writes = 0;
  int doneCount = 0, cycleCnt = 0, lastWrCycle = 0, strobesInReset = 0;
  logic [11:0] lastRd [4];
  logic [2:0]  lastRdSel = 3'b000;

  maxpool_flatten #(.IMG_W(64), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  // Layer-0 memory model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (crd) cdata_rd <= (csel == 3'b010) ? l0c1[caddr_rd] : l0c0[caddr_rd];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cycleCnt);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},     32'(busy),     0);
    checkOutput({tag, "_done"},     32'(done),     0);
    checkOutput({tag, "_crd"},      32'(crd),      0);
    checkOutput({tag, "_cwr"},      32'(cwr),      0);
    checkOutput({tag, "_caddr_rd"}, 32'(caddr_rd), 0);
    checkOutput({tag, "_caddr_wr"}, 32'(caddr_wr), 0);
    checkOutput({tag, "_cdata_wr"}, 32'(cdata_wr), 0);
    checkOutput({tag, "_csel"},     32'(csel),     0);
  endtask

  task automatic loadMemory();
    for (int i = 0; i < 4096; i++) begin
      l0c0[i] = DW'(i);
      l0c1[i] = DW'(i + 8192);
    end
    l0c0[0]  = 20'hFFFFF;
    l0c0[1]  = 20'hFFFFE;
    l0c0[64] = 20'h80000;
    l0c0[65] = 20'hFFFFD;
    l0c0[2]  = 20'h7FFFF;
    l0c0[3]  = 20'h80000;
    l0c0[66] = 20'h00000;
    l0c0[67] = 20'h00001;
  endtask

  // Expected traffic: ramp max is the bottom-right pixel, 128r+2c+65.
  task automatic pushExpected();
    int base, val, n;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        for (int ch = 0; ch < 2; ch++) begin
          base = 128 * r + 2 * c;
          val  = base + 65 + (ch == 1 ? 8192 : 0);
          if (r == 0 && c == 0 && ch == 0) val = 32'hFFFFF;
          if (r == 0 && c == 1 && ch == 0) val = 32'h7FFFF;
          n = 32 * r + c;
          rdQ.push_back('{sel: 3'(1 + ch), addr: 12'(base)});
          rdQ.push_back('{sel: 3'(1 + ch), addr: 12'(base + 1)});
          rdQ.push_back('{sel: 3'(1 + ch), addr: 12'(base + 64)});
          rdQ.push_back('{sel: 3'(1 + ch), addr: 12'(base + 65)});
          wrQ.push_back('{sel: 3'(3 + ch), addr: 12'(n), data: DW'(val)});
          wrQ.push_back('{sel: 3'b101, addr: 12'(2 * n + ch), data: DW'(val)});
        end
  endtask

  task automatic applyStimulus(input bit pokeStart);
    int b0, r0, r1, w0, d0;
    bit poked;
    b0 = busyCycles; r0 = crdCh0; r1 = crdCh1; w0 = l2Writes; d0 = doneCount;
    poked = 1'b0;
    pushExpected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_rise", 32'(busy), 1);
    for (int n = 0; n < 20000 && doneCount == d0; n++) begin
      if (pokeStart && !poked && busyCycles - b0 >= 500) begin
        poked = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    checkOutput("done_pulses",  32'(doneCount - d0), 1);
    checkOutput("busy_cycles",  32'(busyCycles - b0), 14336);
    checkOutput("crd_ch0",      32'(crdCh0 - r0), 4096);
    checkOutput("crd_ch1",      32'(crdCh1 - r1), 4096);
    checkOutput("l2_writes",    32'(l2Writes - w0), 2048);
    checkOutput("writes_left",  32'(wrQ.size()), 0);
    checkOutput("reads_left",   32'(rdQ.size()), 0);
    checkOutput("busy_after",   32'(busy), 0);
    checkOutput("done_one_cyc", 32'(done), 0);
  endtask

  // Monitor: every strobe is matched against the scoreboard queues.
  always @(negedge clk) begin
    rd_t er;
    wr_t ew;
    cycleCnt++;
    if (reset !== 1'b1) begin
      if (crd || cwr) strobesInReset++;
    end else begin
      if (busy) busyCycles++;
      if (!crd && !cwr) checkOutput("csel_idle", 32'(csel), 0);
      else              checkOutput("strobe_exclusive", 32'(crd && cwr), 0);
      if (crd) begin
        if (rdQ.size() == 0) begin
          checkOutput("read_unexpected", 32'(caddr_rd), 32'hFFFF_FFFF);
        end else begin
          er = rdQ.pop_front();
          checkOutput("rd_addr", 32'(caddr_rd), 32'(er.addr));
          checkOutput("rd_sel",  32'(csel),     32'(er.sel));
        end
        if (csel == 3'b001) crdCh0++;
        if (csel == 3'b010) crdCh1++;
        lastRd[0] = lastRd[1];
        lastRd[1] = lastRd[2];
        lastRd[2] = lastRd[3];
        lastRd[3] = caddr_rd;
        lastRdSel = csel;
      end
      if (cwr) begin
        if (wrQ.size() == 0) begin
          checkOutput("write_unexpected", 32'(caddr_wr), 32'hFFFF_FFFF);
        end else begin
          ew = wrQ.pop_front();
          checkOutput("wr_sel",  32'(csel),     32'(ew.sel));
          checkOutput("wr_addr", 32'(caddr_wr), 32'(ew.addr));
          checkOutput("wr_data", 32'(cdata_wr), 32'(ew.data));
        end
        if (csel == 3'b101) l2Writes++;
        lastWrCycle = cycleCnt;
      end
      if (done) begin
        doneCount++;
        checkOutput("done_gap",       32'(cycleCnt - lastWrCycle), 1);
        checkOutput("busy_at_done",   32'(busy), 0);
        checkOutput("last_rd0",       32'(lastRd[0]), 4030);
        checkOutput("last_rd1",       32'(lastRd[1]), 4031);
        checkOutput("last_rd2",       32'(lastRd[2]), 4094);
        checkOutput("last_rd3",       32'(lastRd[3]), 4095);
        checkOutput("last_rd_sel",    32'(lastRdSel), 2);
      end
    end
  end

  initial begin
    int b0, s0;
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) lastRd[i] = 12'd0;
    loadMemory();
    repeat (3) @(negedge clk);
    checkResetOutputs("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] run 1: full pass with a start poke while busy");
    applyStimulus(1'b1);

    $display("[TB] run 2: abort with reset mid-run");
    b0 = busyCycles;
    pushExpected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 10000 && busyCycles - b0 < 7000; n++) @(negedge clk);
    checkOutput("abort_reached", 32'(busyCycles - b0 >= 7000), 1);
    #2 reset = 1'b0;
    #1 checkResetOutputs("midrun");
    wrQ.delete();
    rdQ.delete();
    s0 = strobesInReset;
    repeat (5) @(negedge clk);
    checkOutput("strobes_in_reset", 32'(strobesInReset - s0), 0);
    #2 reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("idle_after_reset", 32'(busy), 0);

    $display("[TB] run 3: fresh run after abort");
    applyStimulus(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_flatten.md
MAXPOOL_FLATTEN -- requirements
Module: maxpool_flatten

Interface
REQ-001 Parameter IMG_W, default 64: layer-0 feature-map width and height in pixels.
REQ-002 Parameter DW, default 20: data width in bits.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: one-cycle request to begin pooling; layer-0 memories are already filled by the conv stage.
REQ-006 busy  output  1: high while an operation is in progress.
REQ-007 done  output  1: one-cycle pulse when the last write completes.
REQ-008 crd  output  1: layer memory read strobe.
REQ-009 caddr_rd  output  12: layer memory read address.
REQ-010 cdata_rd  input  DW: read data, valid one cycle after the crd cycle.
REQ-011 cwr  output  1: layer memory write strobe.
REQ-012 caddr_wr  output  12: layer memory write address.
REQ-013 cdata_wr  output  DW: layer memory write data.
REQ-014 csel  output  3: memory select, encoded as below.
- 001 = layer-0 channel 0
- 010 = layer-0 channel 1
- 011 = layer-1 channel 0
- 100 = layer-1 channel 1
- 101 = layer-2 (flatten)
- 000 = none

Function
REQ-015 The block SHALL perform 2x2 stride-2 max pooling on each 64x64 layer-0 channel, producing a 32x32 map per channel.
REQ-016 Processing order SHALL be row r=0..31, then column c=0..31, then channel ch=0..1 (innermost).
REQ-017 Each (r,c,ch) group SHALL take exactly 7 cycles, with no overlap between groups.
- k=0..3: crd=1, csel=001+ch; caddr_rd = A, A+1, A+64, A+65, where A = 2r*64 + 2c.
- k=4: crd=0, cwr=0, csel=000.
- k=5: cwr=1, csel=011+ch, caddr_wr = r*32+c, cdata_wr = max.
- k=6: cwr=1, csel=101, caddr_wr = 2*(r*32+c)+ch, cdata_wr = max.
REQ-018 cdata_rd SHALL be captured at cycles k=1..4. The max SHALL be a signed two's-complement comparison over the four values; the first value initialises the running max.
REQ-019 When two values are equal, either value SHALL be taken; the output value is identical in both cases.
REQ-020 crd and cwr SHALL never be high in the same cycle. csel SHALL be 000 whenever both strobes are low.
REQ-021 FSM states SHALL be IDLE, READ, CMP, WR_L1, WR_L2, NEXT and DONE.
- IDLE -> READ on start.
- READ loops 4 cycles -> CMP -> WR_L1 -> WR_L2.
- WR_L2 -> READ for the next group, or -> DONE after (31,31,1).
- DONE -> IDLE.
REQ-022 busy SHALL rise in the cycle after start is sampled and fall in the same cycle that done pulses. Total time is 2048*7 = 14336 busy cycles, plus 1 DONE cycle.
REQ-023 start SHALL be ignored while busy or during DONE.
REQ-024 Address arithmetic SHALL be 12-bit unsigned. The maximum read address is 4095 and the maximum write address is 2047; no wrap-around occurs.
REQ-025 cdata_wr SHALL hold the last written value when cwr=0; it is a don't-care for memory.

Reset
REQ-026 While reset=0, the state SHALL be IDLE and these outputs SHALL be 0: busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel. The r, c, ch and k counters and the max register SHALL also be cleared.
REQ-027 Reset asserted mid-operation SHALL abort immediately, with no further reads or writes.
REQ-028 After reset release, the block SHALL wait in IDLE for a new start, and the next run SHALL begin at (0,0,0).

Verification
REQ-029 Ramp: layer-0 ch0[i]=i, ch1[i]=i+8192, start.
- Layer-1 ch0[r*32+c] = 128r+2c+65.
- Layer-1 ch1 equals the ch0 value + 8192.
- Layer-2[2n], [2n+1] interleave ch0 and ch1.
REQ-030 Signed values: window values {0xFFFFF, 0xFFFFE, 0x80000, 0xFFFFD} -> output 0xFFFFF. Window {0x7FFFF, 0x80000, 0, 1} -> output 0x7FFFF.
REQ-031 Boundary group (31,31,1):
- Reads at 4030, 4031, 4094, 4095 with csel=010.
- Writes layer-1 address 1023 with csel=100, then layer-2 address 2047 with csel=101.
- done pulses the next cycle.
REQ-032 Timing:
- Exactly 14336 busy cycles.
- Exactly 4096 crd=1 cycles per channel.
- 2048 layer-2 writes.
- crd and cwr never both high.
REQ-033 Start while busy: pulse start at busy cycle 500 -> no restart, and write sequence and total latency are unchanged.
REQ-034 Reset mid-run: assert reset=0 at busy cycle 7000 -> all outputs 0 within the same cycle and no further cwr. A fresh start then produces the full correct result from (0,0,0).
